cordic_vectoring_iter: RTL and testbench

- Iterative (one micro-rotation per clock) CORDIC engine, vectoring mode only.
- Inverse direction of the rotation-mode `cordic` datapath: takes a Cartesian vector (x, y) and returns its gain-scaled magnitude and its angle.
- Sits beside `cordic` and shares its 16-bit sample format and 16-bit-per-iteration angle trace layout.
- Used for phase/magnitude recovery, with a valid/ready handshake on input and output.

---
 rtl/cordic_vectoring_iter.sv | 156 +++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter.sv
`default_nettype none
// =============================================================================
// cordic_vectoring_iter : iterative vectoring-mode CORDIC, one micro-rotation
// per clock; returns gain-scaled magnitude and binary angle of (x, y).
// Revision: 1.0
// =============================================================================
module cordic_vectoring_iter #(
   parameter int ITERATIONS = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [15:0]  x_in,
   input  logic [15:0]  y_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [16:0]  mag_out,
   output logic [15:0]  angle_out,
   output logic [127:0] z_trace
);
   localparam logic [2:0] C_LAST = 3'(ITERATIONS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic signed [17:0] r_x;
   logic signed [17:0] r_y;
   logic        [15:0] r_z;
   logic        [2:0]  r_cnt;
   logic               r_zero;
   logic        [16:0] r_mag;
   logic        [15:0] r_angle;
   logic        [127:0] r_trace;

   logic signed [17:0] w_xe;
   logic signed [17:0] w_ye;
   logic signed [17:0] w_x_pre;
   logic signed [17:0] w_y_pre;
   logic        [15:0] w_z_pre;
   logic signed [17:0] w_x_sh;
   logic signed [17:0] w_y_sh;
   logic signed [17:0] w_x_next;
   logic signed [17:0] w_y_next;
   logic        [15:0] w_z_next;
   logic        [15:0] w_atan;
   logic               w_accept;
   logic               w_last;

   assign w_xe      = {{2{x_in[15]}}, x_in};
   assign w_ye      = {{2{y_in[15]}}, y_in};
   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign w_last    = (r_cnt == C_LAST);
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign mag_out   = r_mag;
   assign angle_out = r_angle;
   assign z_trace   = r_trace;

   // Fold the left half-plane onto the right by +/-90 degrees; 18 bits keep -(-32768) exact.
   always_comb begin
      w_x_pre = w_xe;
      w_y_pre = w_ye;
      w_z_pre = 16'd0;
      if (x_in[15]) begin
         if (!y_in[15]) begin
            w_x_pre = w_ye;
            w_y_pre = -w_xe;
            w_z_pre = 16'd16384;
         end else begin
            w_x_pre = -w_ye;
            w_y_pre = w_xe;
            w_z_pre = 16'hC000;
         end
      end
   end

   always_comb begin
      case (r_cnt)
         3'd0:    w_atan = 16'd8192;
         3'd1:    w_atan = 16'd4836;
         3'd2:    w_atan = 16'd2555;
         3'd3:    w_atan = 16'd1297;
         3'd4:    w_atan = 16'd651;
         3'd5:    w_atan = 16'd326;
         3'd6:    w_atan = 16'd163;
         default: w_atan = 16'd81;
      endcase
   end

   assign w_x_sh = r_x >>> r_cnt;
   assign w_y_sh = r_y >>> r_cnt;

   // Rotate towards y = 0; the angle accumulator wraps naturally at 16 bits.
   always_comb begin
      w_x_next = r_x + w_y_sh;
      w_y_next = r_y - w_x_sh;
      w_z_next = r_z + w_atan;
      if (r_y[17]) begin
         w_x_next = r_x - w_y_sh;
         w_y_next = r_y + w_x_sh;
         w_z_next = r_z - w_atan;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_ITER;
         S_ITER:  if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_cnt   <= '0;
         r_zero  <= 1'b0;
         r_mag   <= '0;
         r_angle <= '0;
         r_trace <= '0;
      end else if (w_accept) begin
         r_x     <= w_x_pre;
         r_y     <= w_y_pre;
         r_z     <= w_z_pre;
         r_cnt   <= '0;
         r_zero  <= (x_in == 16'd0) && (y_in == 16'd0);
         r_trace <= '0;
      end else if (r_state == S_ITER) begin
         r_x                         <= w_x_next;
         r_y                         <= w_y_next;
         r_z                         <= w_z_next;
         r_cnt                       <= r_cnt + 3'd1;
         r_trace[{r_cnt, 4'd0} +: 16] <= w_z_next;
         if (w_last) begin
            r_mag   <= r_zero ? 17'd0 : w_x_next[16:0];
            r_angle <= r_zero ? 16'd0 : w_z_next;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring_iter.sv
`default_nettype none
// Testbench for cordic_vectoring_iter: randomized vectors checked every output-valid
// cycle against an integer reference model, plus literal trig expectations.
module tb_cordic_vectoring_iter;
   localparam int ITER = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [15:0]  x_in = '0;
   logic [15:0]  y_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [16:0]  mag_out;
   logic [15:0]  angle_out;
   logic [127:0] z_trace;

   int checks = 0;
   int errors = 0;
   int e_mag, e_ang;
   logic [127:0] e_trace;
   logic e_ok = 1'b0;
   int atan_t [8] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81};

   cordic_vectoring_iter #(.ITERATIONS(ITER)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
      .mag_out(mag_out), .angle_out(angle_out), .z_trace(z_trace)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic chk_tr(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_tol(input string name, input int act, input int req, input int tol);
      checks++;
      if (act - req > tol || req - act > tol) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d+-%0d", name, act, req, tol);
      end
   endtask

   function automatic int angdiff(input int a, input int b);
      int d;
      d = (a - b) & 32'hFFFF;
      if (d >= 32768) d -= 65536;
      return d;
   endfunction

   // Reference: quadrant fold followed by ITER shift-and-add micro-rotations on plain integers.
   function automatic void model(input int xi, input int yi, output int mag, output int ang,
                                 output logic [127:0] tr);
      int x, y, z, xn, yn;
      if (xi >= 0)      begin x = xi;  y = yi;  z = 0;      end
      else if (yi >= 0) begin x = yi;  y = -xi; z = 16384;  end
      else              begin x = -yi; y = xi;  z = -16384; end
      tr = '0;
      for (int i = 0; i < ITER; i++) begin
         if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); z += atan_t[i]; end
         else        begin xn = x - (y >>> i); yn = y + (x >>> i); z -= atan_t[i]; end
         x = xn; y = yn;
         tr[16*i +: 16] = 16'(z);
      end
      if (xi == 0 && yi == 0) begin mag = 0; ang = 0; end
      else begin mag = x & 32'h1FFFF; ang = z & 32'hFFFF; end
   endfunction

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (!e_ok) chk("unexpected_out_valid", 1, 0);
         chk("mag_model", mag_out, e_mag);
         chk("angle_model", angle_out, e_ang);
         chk_tr("trace_model", z_trace, e_trace);
      end
   end

   // One transaction; literal tolerances below 0 skip the literal checks.
   task automatic do_op(input int x, input int y, input int hold,
                        input int lmag, input int mtol, input int lang, input int atol);
      int lat;
      @(negedge clk);
      x_in = 16'(x); y_in = 16'(y); in_valid = 1'b1;
      model(x, y, e_mag, e_ang, e_trace);
      e_ok = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, ITER);
      if (mtol >= 0) chk_tol("mag_literal", int'(mag_out), lmag, mtol);
      if (atol >= 0) chk_tol("angle_literal", angdiff(int'(angle_out), lang), 0, atol);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_out_valid", out_valid, 1);
         x_in = 16'($urandom); y_in = 16'($urandom); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("handshake_out_valid", out_valid, 0);
      chk("handshake_in_ready", in_ready, 1);
      chk("keep_mag", mag_out, e_mag);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mag", mag_out, 0);
      chk("rst_angle", angle_out, 0);
      chk_tr("rst_trace", z_trace, '0);
      @(negedge clk) reset = 1'b0;

      do_op(1000, 0, 0, 1646, 4, 0, 96);
      chk("slot0_x", z_trace[15:0], 8192);
      do_op(0, 1000, 0, 1646, 4, 16384, 96);
      chk("slot0_y", z_trace[15:0], 8192);
      do_op(-1000, -1000, 0, 2329, 6, -24576, 96);
      chk("slot0_q3", z_trace[15:0], 16'hA000);
      do_op(-32768, 0, 0, 53961, 64, -32768, 96);
      do_op(0, 0, 0, 0, 0, 0, 0);
      do_op(1234, -567, 5, 0, -1, 0, -1);
      do_op(-32768, -32768, 1, 0, -1, 0, -1);
      do_op(32767, 32767, 0, 0, -1, 0, -1);
      do_op(-32768, 32767, 2, 0, -1, 0, -1);

      // Reset in the middle of iteration 4 discards the operation.
      @(negedge clk);
      x_in = 16'd3000; y_in = 16'd2000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk_tr("mid_rst_trace", z_trace, '0);
      chk("mid_rst_mag", mag_out, 0);
      chk("mid_rst_angle", angle_out, 0);
      @(negedge clk) reset = 1'b0;
      do_op(-500, 700, 0, 0, -1, 0, -1);

      for (int k = 0; k < 24; k++)
         do_op(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
               int'($urandom_range(0, 3)), 0, -1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
